// File: rtl/multi_operand_adder_signed_sat_pkg.sv
// ee526_adder_pkg: shared FSM states and signed range helpers
package ee526_adder_pkg;
  typedef enum logic {ACCUM, HOLD} state_t;
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/multi_operand_adder_signed_sat_signed_saturate.sv
// signed_saturate: narrows a signed value to OUT_W bits, clamping or wrapping, and flags out-of-range
module signed_saturate
  import ee526_adder_pkg::*;
#(
  parameter int IN_W  = 11,
  parameter int OUT_W = 8
) (
  input  logic signed [IN_W-1:0] value,
  input  logic                   sat_en,
  output logic [OUT_W-1:0]       result,
  output logic                   ovf
);
  localparam logic signed [IN_W-1:0] hi = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] lo = IN_W'(sat_min(OUT_W));
  logic hi_ovf;
  logic lo_ovf;
  // Range test in the wide domain, then pick clamp or truncation
  always_comb begin
    hi_ovf = value > hi;
    lo_ovf = value < lo;
    ovf = hi_ovf || lo_ovf;
    result = (sat_en && hi_ovf) ? hi[OUT_W-1:0] : (sat_en && lo_ovf) ? lo[OUT_W-1:0] : value[OUT_W-1:0];
  end
endmodule

// File: rtl/multi_operand_adder_signed_sat.sv
// multi_operand_adder_signed_sat: streaming signed group accumulator with saturating/wrapping result
module multi_operand_adder_signed_sat
  import ee526_adder_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 5,
  parameter int OUT_WIDTH    = 8,
  localparam int ACC_W = WIDTH + $clog2(NUM_OPERANDS),
  localparam int CNT_W = $clog2(NUM_OPERANDS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sat_en,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_ovf,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);
  state_t state;
  state_t state_n;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] nsum;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] ncount;
  logic fire;
  logic done;
  logic [OUT_WIDTH-1:0] sat_data;
  logic sat_ovf;
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  // Next sum/count for the offered beat and the group-end decision
  always_comb begin
    nsum = acc + {{(ACC_W-WIDTH){in_data[WIDTH-1]}}, in_data};
    ncount = count + CNT_W'(1);
    fire = in_valid && in_ready;
    done = fire && (in_last || ncount == CNT_W'(NUM_OPERANDS));
    state_n = (state == ACCUM) ? (done ? HOLD : ACCUM) : (out_ready ? ACCUM : HOLD);
  end
  signed_saturate #(.IN_W(ACC_W), .OUT_W(OUT_WIDTH)) u_sat (
    .value (nsum),
    .sat_en(sat_en),
    .result(sat_data),
    .ovf   (sat_ovf)
  );
  // State, accumulator and result register; result captured on the final beat only
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      out_data <= '0;
      out_ovf <= 1'b0;
      out_count <= '0;
    end else begin
      state <= state_n;
      if (fire) begin
        acc <= done ? '0 : nsum;
        count <= done ? '0 : ncount;
      end
      if (done) begin
        out_data <= sat_data;
        out_ovf <= sat_ovf;
        out_count <= ncount;
      end
    end
  end
endmodule

// File: tb/tb_multi_operand_adder_signed_sat.sv
// tb_multi_operand_adder_signed_sat: directed checks of grouping, saturation, wrap, backpressure and reset
module tb_multi_operand_adder_signed_sat;
  logic clk = 0;
  logic reset = 1;
  logic sat_en = 1;
  logic [7:0] in_data = 0;
  logic in_valid = 0;
  logic in_last = 0;
  logic in_ready;
  logic [7:0] out_data;
  logic out_ovf;
  logic [2:0] out_count;
  logic out_valid;
  logic out_ready = 0;
  int n_cmp = 0;
  int n_err = 0;
  multi_operand_adder_signed_sat dut (
    .clk(clk), .reset(reset), .sat_en(sat_en), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_ovf(out_ovf),
    .out_count(out_count), .out_valid(out_valid), .out_ready(out_ready)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic beat(input logic [7:0] d, input logic l);
    in_data = d;
    in_valid = 1;
    in_last = l;
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic res(input string tag, input logic [7:0] d, input logic o, input logic [2:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
  endtask
  task automatic take(input string tag);
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 0);
    chk({tag, "_ready_rise"}, 32'(in_ready), 1);
  endtask
  task automatic idle_state(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"}, 32'(out_data), 0);
    chk({tag, "_ovf"}, 32'(out_ovf), 0);
    chk({tag, "_count"}, 32'(out_count), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    idle_state("reset");
    reset = 0;
    beat(8'd10, 0); beat(8'd20, 0); beat(8'd30, 0); beat(8'd40, 0); beat(8'd27, 0);
    res("sum127", 8'h7F, 0, 3'd5);
    take("sum127");
    repeat (5) beat(8'd100, 0);
    res("sat_pos", 8'h7F, 1, 3'd5);
    take("sat_pos");
    beat(8'd100, 0); beat(8'd100, 0); beat(8'd100, 0); beat(8'd100, 0);
    sat_en = 0;
    beat(8'd100, 0);
    res("wrap_pos", 8'hF4, 1, 3'd5);
    sat_en = 1;
    take("wrap_pos");
    repeat (5) beat(8'h80, 0);
    res("sat_neg", 8'h80, 1, 3'd5);
    take("sat_neg");
    repeat (5) beat(8'hFF, 0);
    res("neg5", 8'hFB, 0, 3'd5);
    take("neg5");
    beat(8'd5, 0); beat(8'hFD, 1);
    res("short2", 8'd2, 0, 3'd2);
    take("short2");
    beat(8'd7, 1);
    res("single", 8'd7, 0, 3'd1);
    take("single");
    beat(8'd1, 0); beat(8'd2, 0); beat(8'd3, 1);
    res("bp_group", 8'd6, 0, 3'd3);
    in_data = 8'd9;
    in_valid = 1;
    repeat (3) begin
      @(posedge clk); #1;
      res("bp_hold", 8'd6, 0, 3'd3);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk("bp_valid_drop", 32'(out_valid), 0);
    chk("bp_ready_rise", 32'(in_ready), 1);
    in_last = 1;
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
    res("bp_next", 8'd9, 0, 3'd1);
    take("bp_next");
    beat(8'd50, 0);
    in_last = 1;
    @(posedge clk); #1;
    in_last = 0;
    chk("last_no_valid", 32'(out_valid), 0);
    beat(8'd50, 0); beat(8'd50, 0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    idle_state("mid_reset");
    repeat (5) beat(8'd1, 0);
    res("after_reset", 8'd5, 0, 3'd5);
    take("after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
